// File: rtl/sad_accum.sv
// sad_accum -- sum-of-absolute-differences accumulator for block-match search.
//
// Accumulates, over ROWS rows, the SAD between one current-block row and
// eight candidate rows per cycle, then picks the candidate with the smallest
// total. Lowest index wins ties.
//
// Ports
//   clk_i                clock, all state changes on its rising edge
//   rst_i                synchronous active-high reset
//   start_i              one-cycle pulse, begins a search (IDLE only)
//   row_valid_i          qualifies cur_row_i / ad_data*_i (ACCUM only)
//   cur_row_i            current row, 16 pixels, pixel p at [8p+7:8p]
//   ad_data0_i..7_i      candidate rows k=0..7, same pixel layout
//   busy_o               high whenever the FSM is not IDLE
//   done_o               one-cycle result-valid pulse
//   best_idx_o           index of minimum-SAD candidate (registered)
//   best_sad_o           minimum SAD (registered)

// Per-candidate row SAD: 16 unsigned 8-bit absolute differences, max 4080.
module sad_row (
   input  logic [127:0] cur,
   input  logic [127:0] cand,
   output logic [11:0]  sum
);
   always_comb begin
      sum = '0;
      for (int p = 0; p < 16; p++) begin
         if (cur[8*p +: 8] > cand[8*p +: 8])
            sum = sum + 12'(cur[8*p +: 8] - cand[8*p +: 8]);
         else
            sum = sum + 12'(cand[8*p +: 8] - cur[8*p +: 8]);
      end
   end
endmodule

module sad_accum #(
   parameter int ROWS = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         row_valid_i,
   input  logic [127:0] cur_row_i,
   input  logic [127:0] ad_data0_i,
   input  logic [127:0] ad_data1_i,
   input  logic [127:0] ad_data2_i,
   input  logic [127:0] ad_data3_i,
   input  logic [127:0] ad_data4_i,
   input  logic [127:0] ad_data5_i,
   input  logic [127:0] ad_data6_i,
   input  logic [127:0] ad_data7_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [2:0]   best_idx_o,
   output logic [15:0]  best_sad_o
);
   localparam int NUM_CAND = 8;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ACCUM   = 3'd1;
   localparam logic [2:0] FLUSH   = 3'd2;
   localparam logic [2:0] COMPARE = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]                        state;
   logic [4:0]                        row_cnt;
   logic [NUM_CAND-1:0][127:0]        cand;
   logic [NUM_CAND-1:0][11:0]         row_sum_d;
   logic [NUM_CAND-1:0][11:0]         row_sum;
   logic                              sum_vld;   // row_sum holds an un-added row
   logic [NUM_CAND-1:0][15:0]         acc;
   logic [2:0]                        cmp_idx;
   logic [15:0]                       cmp_acc;
   logic                              accept;
   logic                              last_row;

   assign cand = {ad_data7_i, ad_data6_i, ad_data5_i, ad_data4_i,
                  ad_data3_i, ad_data2_i, ad_data1_i, ad_data0_i};

   genvar k;
   generate
      for (k = 0; k < NUM_CAND; k++) begin : g_row
         sad_row u_row (
            .cur  (cur_row_i),
            .cand (cand[k]),
            .sum  (row_sum_d[k])
         );
      end
   endgenerate

   assign accept   = (state == ACCUM) && row_valid_i;
   assign last_row = accept && (row_cnt == 5'(ROWS - 1));
   assign cmp_acc  = acc[cmp_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         row_cnt    <= '0;
         row_sum    <= '0;
         sum_vld    <= 1'b0;
         acc        <= '0;
         cmp_idx    <= '0;
         best_idx_o <= '0;
         best_sad_o <= '0;
      end else begin
         // Row sums are registered on acceptance and added one edge later;
         // FLUSH exists only to retire the add of the final row.
         sum_vld <= accept;
         if (accept) row_sum <= row_sum_d;
         if (sum_vld) begin
            for (int i = 0; i < NUM_CAND; i++)
               acc[i] <= acc[i] + 16'(row_sum[i]);
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  state   <= ACCUM;
                  row_cnt <= '0;
                  acc     <= '0;
               end
            end
            ACCUM: begin
               if (accept) row_cnt <= row_cnt + 5'd1;
               if (last_row) state <= FLUSH;
            end
            FLUSH: begin
               cmp_idx <= '0;
               state   <= COMPARE;
            end
            COMPARE: begin
               // Strict less-than keeps the lower index on ties.
               if (cmp_idx == 3'd0 || cmp_acc < best_sad_o) begin
                  best_idx_o <= cmp_idx;
                  best_sad_o <= cmp_acc;
               end
               cmp_idx <= cmp_idx + 3'd1;
               if (cmp_idx == 3'd7) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o = (state != IDLE);
   assign done_o = (state == DONE);
endmodule
